// File: rtl/fft_sdf_r2_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage: first half of each 2*DELAY frame fills the delay line,
// second half emits (a+b)/2 and feeds back (a-b)/2, which leaves twiddled during the next first half.
module fft_sdf_r2_stage #(
   parameter int DELAY    = 16,
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       flush,
   input  logic signed [WIDTH-1:0]    in_r,
   input  logic signed [WIDTH-1:0]    in_i,
   output logic [3:0]                 tw_idx,
   input  logic signed [TW_WIDTH-1:0] tw_r,
   input  logic signed [TW_WIDTH-1:0] tw_i,
   output logic                       out_valid,
   output logic signed [WIDTH-1:0]    out_r,
   output logic signed [WIDTH-1:0]    out_i
);
   localparam int CW   = $clog2(2 * DELAY);
   localparam int SW   = WIDTH + 1;
   localparam int PW   = WIDTH + TW_WIDTH + 1;
   localparam int FRAC = 14;
   localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] MINV = ~MAXV;
   localparam logic signed [PW-1:0] RND  = PW'(64'sd1 <<< (FRAC - 1));

   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     primed_q, primed_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0]  out_r_q, out_r_d, out_i_q, out_i_d;
   logic signed [WIDTH-1:0]  dl_r_q [DELAY];
   logic signed [WIDTH-1:0]  dl_r_d [DELAY];
   logic signed [WIDTH-1:0]  dl_i_q [DELAY];
   logic signed [WIDTH-1:0]  dl_i_d [DELAY];

   logic                     adv, phase_b, emit;
   logic signed [WIDTH-1:0]  x_r, x_i, head_r, head_i;
   logic signed [WIDTH-1:0]  sum_r, sum_i, dif_r, dif_i, mul_r, mul_i;
   logic signed [PW-1:0]     pr_full, pi_full;

   function automatic logic signed [WIDTH-1:0] half(input logic signed [SW-1:0] v);
      return WIDTH'(v >>> 1);
   endfunction

   function automatic logic signed [WIDTH-1:0] rnd_sat(input logic signed [PW-1:0] v);
      logic signed [PW-1:0] s;
      s = (v + RND) >>> FRAC;
      if (s > MAXV)      return MAXV[WIDTH-1:0];
      else if (s < MINV) return MINV[WIDTH-1:0];
      else               return s[WIDTH-1:0];
   endfunction

   assign adv     = in_valid | flush;
   assign x_r     = in_valid ? in_r : '0;
   assign x_i     = in_valid ? in_i : '0;
   // 2*DELAY is a power of two, so the counter MSB marks the second half.
   assign phase_b = cnt_q[CW-1];
   assign head_r  = dl_r_q[DELAY-1];
   assign head_i  = dl_i_q[DELAY-1];
   assign emit    = adv & (primed_q | (cnt_q == CW'(DELAY)));

   assign sum_r   = half(SW'(head_r) + SW'(x_r));
   assign sum_i   = half(SW'(head_i) + SW'(x_i));
   assign dif_r   = half(SW'(head_r) - SW'(x_r));
   assign dif_i   = half(SW'(head_i) - SW'(x_i));
   assign pr_full = PW'(head_r) * PW'(tw_r) - PW'(head_i) * PW'(tw_i);
   assign pi_full = PW'(head_r) * PW'(tw_i) + PW'(head_i) * PW'(tw_r);
   assign mul_r   = rnd_sat(pr_full);
   assign mul_i   = rnd_sat(pi_full);

   generate
      if (DELAY == 1) begin : g_tw_fixed
         assign tw_idx = 4'd0;
      end else begin : g_tw_cnt
         assign tw_idx = 4'(cnt_q[$clog2(DELAY)-1:0]);
      end
   endgenerate

   always_comb begin
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      out_valid_d = emit;
      out_r_d     = out_r_q;
      out_i_d     = out_i_q;
      dl_r_d      = dl_r_q;
      dl_i_d      = dl_i_q;
      if (adv) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(DELAY)) primed_d = 1'b1;
         for (int i = 1; i < DELAY; i++) begin
            dl_r_d[i] = dl_r_q[i-1];
            dl_i_d[i] = dl_i_q[i-1];
         end
         dl_r_d[0] = phase_b ? dif_r : x_r;
         dl_i_d[0] = phase_b ? dif_i : x_i;
      end
      if (emit) begin
         out_r_d = phase_b ? sum_r : mul_r;
         out_i_d = phase_b ? sum_i : mul_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_r_q     <= '0;
         out_i_q     <= '0;
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         out_r_q     <= out_r_d;
         out_i_q     <= out_i_d;
      end
   end

   // Delay-line contents are never read before primed is set, so they carry no reset.
   always_ff @(posedge clk) begin
      dl_r_q <= dl_r_d;
      dl_i_q <= dl_i_d;
   end

   assign out_valid = out_valid_q;
   assign out_r     = out_r_q;
   assign out_i     = out_i_q;
endmodule

// File: tb/tb_fft_sdf_r2_stage.sv
// Bench for the SDF radix-2 stage: directed vector table on DELAY=1, frame-level reference model on DELAY=4/8.
module tb_fft_sdf_r2_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0, flush = 1'b0;
   logic signed [15:0] in_r = '0, in_i = '0;

   logic [3:0] tw1_idx, tw4_idx, tw8_idx, m4, m8;
   logic signed [15:0] tw1_r, tw1_i, tw4_r, tw4_i, tw8_r, tw8_i;
   logic o1_vld, o4_vld, o8_vld;
   logic signed [15:0] o1_r, o1_i, o4_r, o4_i, o8_r, o8_i;

   logic signed [15:0] cos_t [16];
   logic signed [15:0] nsin_t [16];
   int tw_mode = 0;
   logic signed [15:0] tc_r = 16'sd16384, tc_i = '0;
   int sel = 1;

   always #5 clk = ~clk;

   // Twiddle ROM: e^{-j*2*pi*m/32}, m = idx * 16/DELAY; mode 0 forces a constant W.
   assign m4 = {tw4_idx[1:0], 2'b00};
   assign m8 = {tw8_idx[2:0], 1'b0};
   assign tw1_r = (tw_mode != 0) ? cos_t[0]   : tc_r;
   assign tw1_i = (tw_mode != 0) ? nsin_t[0]  : tc_i;
   assign tw4_r = (tw_mode != 0) ? cos_t[m4]  : tc_r;
   assign tw4_i = (tw_mode != 0) ? nsin_t[m4] : tc_i;
   assign tw8_r = (tw_mode != 0) ? cos_t[m8]  : tc_r;
   assign tw8_i = (tw_mode != 0) ? nsin_t[m8] : tc_i;

   fft_sdf_r2_stage #(.DELAY(1), .WIDTH(16), .TW_WIDTH(16)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .in_r(in_r), .in_i(in_i),
      .tw_idx(tw1_idx), .tw_r(tw1_r), .tw_i(tw1_i), .out_valid(o1_vld), .out_r(o1_r), .out_i(o1_i));
   fft_sdf_r2_stage #(.DELAY(4), .WIDTH(16), .TW_WIDTH(16)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .in_r(in_r), .in_i(in_i),
      .tw_idx(tw4_idx), .tw_r(tw4_r), .tw_i(tw4_i), .out_valid(o4_vld), .out_r(o4_r), .out_i(o4_i));
   fft_sdf_r2_stage #(.DELAY(8), .WIDTH(16), .TW_WIDTH(16)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .in_r(in_r), .in_i(in_i),
      .tw_idx(tw8_idx), .tw_r(tw8_r), .tw_i(tw8_i), .out_valid(o8_vld), .out_r(o8_r), .out_i(o8_i));

   logic cur_vld;
   logic signed [15:0] cur_r, cur_i;
   assign cur_vld = (sel == 1) ? o1_vld : (sel == 4) ? o4_vld : o8_vld;
   assign cur_r   = (sel == 1) ? o1_r   : (sel == 4) ? o4_r   : o8_r;
   assign cur_i   = (sel == 1) ? o1_i   : (sel == 4) ? o4_i   : o8_i;

   int checks = 0, errors = 0;
   int exp_r[$], exp_i[$];
   int last_r = 0, last_i = 0, n_adv = 0, n_out = 0, first_vld = -1;

   typedef struct {
      bit rs; int wr; int wi; bit v; bit f; int xr; int xi; bit ev; int er; int ei;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic int sat16(input longint p);
      longint q;
      q = (p + 64'sd8192) >>> 14;
      if (q > 32767) return 32767;
      if (q < -32768) return -32768;
      return int'(q);
   endfunction

   function automatic int tw_val(input int d, input int k, input bit imag);
      int m;
      m = k * (16 / d);
      if (tw_mode == 0) return imag ? int'(tc_i) : int'(tc_r);
      return imag ? int'(nsin_t[m]) : int'(cos_t[m]);
   endfunction

   // Output stream of an SDF DIF stage: per frame, D half-sums, then D twiddled half-differences.
   task automatic build_expect(input int d, input int xr[$], input int xi[$]);
      int nf, ar, ai, br, bi, dr, di, wr, wi;
      nf = xr.size() / (2 * d);
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < d; k++) begin
            exp_r.push_back((xr[f*2*d+k] + xr[f*2*d+k+d]) >>> 1);
            exp_i.push_back((xi[f*2*d+k] + xi[f*2*d+k+d]) >>> 1);
         end
         for (int k = 0; k < d; k++) begin
            ar = xr[f*2*d+k]; ai = xi[f*2*d+k]; br = xr[f*2*d+k+d]; bi = xi[f*2*d+k+d];
            dr = (ar - br) >>> 1; di = (ai - bi) >>> 1;
            wr = tw_val(d, k, 1'b0); wi = tw_val(d, k, 1'b1);
            exp_r.push_back(sat16(longint'(dr) * wr - longint'(di) * wi));
            exp_i.push_back(sat16(longint'(dr) * wi + longint'(di) * wr));
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0; flush = 1'b0;
      #1;
      chk("rst_vld_d1", int'(o1_vld), 0); chk("rst_r_d4", int'(o4_r), 0); chk("rst_i_d8", int'(o8_i), 0);
      #2;
      rst = 1'b1;
      exp_r.delete(); exp_i.delete();
      last_r = 0; last_i = 0; n_adv = 0; n_out = 0; first_vld = -1;
   endtask

   task automatic step(input bit v, input bit f, input int r, input int i);
      in_valid = v; flush = f; in_r = 16'(r); in_i = 16'(i);
      @(posedge clk);
      #1;
   endtask

   task automatic step_q(input bit v, input bit f, input int r, input int i);
      step(v, f, r, i);
      if (!(v | f)) begin
         chk("stall_vld", int'(cur_vld), 0);
         chk("stall_hold_r", int'(cur_r), last_r);
         chk("stall_hold_i", int'(cur_i), last_i);
      end else begin
         n_adv++;
         if (cur_vld) begin
            if (first_vld < 0) first_vld = n_adv;
            n_out++;
            if (exp_r.size() == 0) chk("unexpected_out", int'(cur_vld), 0);
            else begin
               last_r = exp_r.pop_front(); last_i = exp_i.pop_front();
               chk($sformatf("out_r#%0d", n_out), int'(cur_r), last_r);
               chk($sformatf("out_i#%0d", n_out), int'(cur_i), last_i);
            end
         end
      end
   endtask

   initial begin
      int xr[$], xi[$];
      int vcnt, vfirst, vlast;
      cos_t  = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
                 0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};
      nsin_t = '{0, -3196, -6270, -9102, -11585, -13623, -15137, -16069,
                 -16384, -16069, -15137, -13623, -11585, -9102, -6270, -3196};

      // DELAY=1 vectors: rs, Wr, Wi, in_valid, flush, in_r, in_i, exp_vld, exp_r, exp_i
      tbl.push_back('{1, 16384, 0, 1, 0, 1000, 0, 0, 0, 0});
      tbl.push_back('{0, 16384, 0, 1, 0, 200, 0, 1, 600, 0});
      tbl.push_back('{0, 16384, 0, 0, 1, 0, 0, 1, 400, 0});
      tbl.push_back('{0, 16384, 0, 0, 0, 0, 0, 0, 400, 0});
      tbl.push_back('{1, 0, -16384, 1, 0, 1000, 0, 0, 0, 0});
      tbl.push_back('{0, 0, -16384, 1, 0, 0, 0, 1, 500, 0});
      tbl.push_back('{0, 0, -16384, 0, 1, 0, 0, 1, 0, -500});
      tbl.push_back('{0, 0, -16384, 0, 0, 0, 0, 0, 0, -500});
      tbl.push_back('{1, 32767, 0, 1, 0, 32767, 0, 0, 0, 0});
      tbl.push_back('{0, 32767, 0, 1, 0, -32768, 0, 1, -1, 0});
      tbl.push_back('{0, 32767, 0, 0, 1, 0, 0, 1, 32767, 0});
      tbl.push_back('{0, 32767, 0, 0, 0, 0, 0, 0, 32767, 0});
      tbl.push_back('{1, 16384, 0, 1, 1, 1000, 0, 0, 0, 0});
      tbl.push_back('{0, 16384, 0, 1, 1, 200, 0, 1, 600, 0});
      tbl.push_back('{0, 16384, 0, 0, 1, 999, 0, 1, 400, 0});
      tbl.push_back('{0, 16384, 0, 0, 1, 555, 0, 1, 0, 0});
      tbl.push_back('{0, 16384, 0, 0, 0, 0, 0, 0, 0, 0});

      rst = 1'b0;
      #12;
      rst = 1'b1;
      @(posedge clk); #1;

      sel = 1; tw_mode = 0;
      foreach (tbl[n]) begin
         if (tbl[n].rs) do_reset();
         tc_r = 16'(tbl[n].wr); tc_i = 16'(tbl[n].wi);
         step(tbl[n].v, tbl[n].f, tbl[n].xr, tbl[n].xi);
         chk($sformatf("tbl%0d_vld", n), int'(o1_vld), int'(tbl[n].ev));
         chk($sformatf("tbl%0d_r", n), int'(o1_r), tbl[n].er);
         chk($sformatf("tbl%0d_i", n), int'(o1_i), tbl[n].ei);
      end

      // DELAY=4 constant frame: 4x1000 sums, 4x0 differences, one contiguous valid burst.
      do_reset();
      sel = 4; tw_mode = 0; tc_r = 16'sd16384; tc_i = '0;
      xr.delete(); xi.delete();
      for (int k = 0; k < 8; k++) begin xr.push_back(1000); xi.push_back(0); end
      build_expect(4, xr, xi);
      vcnt = 0; vfirst = -1; vlast = -1;
      for (int k = 0; k < 12; k++) begin
         if (k < 8) step_q(1'b1, 1'b0, xr[k], xi[k]);
         else       step_q(1'b0, 1'b1, 0, 0);
         if (cur_vld) begin
            vcnt++; vlast = k;
            if (vfirst < 0) vfirst = k;
         end
      end
      chk("t2_first_valid_adv", first_vld, 5);
      chk("t2_valid_count", vcnt, 8);
      chk("t2_valid_span", vlast - vfirst + 1, 8);
      chk("t2_leftover", exp_r.size(), 0);

      // DELAY=4 random frames with a stall after every advance.
      do_reset();
      sel = 4; tw_mode = 1;
      xr.delete(); xi.delete();
      for (int k = 0; k < 24; k++) begin
         xr.push_back(int'($urandom_range(65535)) - 32768);
         xi.push_back(int'($urandom_range(65535)) - 32768);
      end
      build_expect(4, xr, xi);
      for (int k = 0; k < 28; k++) begin
         if (k < 24) step_q(1'b1, 1'b0, xr[k], xi[k]);
         else        step_q(1'b0, 1'b1, 0, 0);
         step_q(1'b0, 1'b0, int'($urandom_range(999)), 0);
      end
      chk("t5_out_count", n_out, 24);
      chk("t5_leftover", exp_r.size(), 0);

      // DELAY=8: reset at cnt=5, then two fresh random frames and a drain.
      do_reset();
      sel = 8; tw_mode = 1;
      for (int k = 0; k < 5; k++)
         step_q(1'b1, 1'b0, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
      do_reset();
      xr.delete(); xi.delete();
      for (int k = 0; k < 32; k++) begin
         xr.push_back(int'($urandom_range(65535)) - 32768);
         xi.push_back(int'($urandom_range(65535)) - 32768);
      end
      build_expect(8, xr, xi);
      for (int k = 0; k < 40; k++) begin
         if (k < 32) step_q(1'b1, 1'b0, xr[k], xi[k]);
         else        step_q(1'b0, 1'b1, 0, 0);
      end
      chk("t6_first_valid_adv", first_vld, 9);
      chk("t6_out_count", n_out, 32);
      chk("t6_leftover", exp_r.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
